// File: rtl/mips_ctrl_pkg.sv
// Shared control-path types for the MIPS control pipeline.
package mips_ctrl_pkg;

  localparam int CTRL_ALUCW = 3;

  // Decoded control bundle as produced by the main/ALU decoder.
  typedef struct packed {
    logic                  regwrite;
    logic                  memtoreg;
    logic                  memwrite;
    logic                  alusrc;
    logic                  regdst;
    logic                  branch;
    logic                  jump;
    logic [CTRL_ALUCW-1:0] alucontrol;
  } ctrl_t;

  // A bubble is an instruction with no architectural side effects.
  localparam ctrl_t CTRL_BUBBLE = '0;

  // ALU operand source select.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_t;

endpackage

// File: rtl/ctrl_pipe_hazard_unit.sv
// Combinational hazard detection: load-use stall, branch/jump redirect
// and ALU operand forwarding selects.
module hazard_unit
  import mips_ctrl_pkg::*;
#(
  parameter int REGW = 5
) (
  input  logic [REGW-1:0] rs_d,
  input  logic [REGW-1:0] rt_d,
  input  logic [REGW-1:0] rs_e,
  input  logic [REGW-1:0] rt_e,
  input  logic [REGW-1:0] writereg_m,
  input  logic [REGW-1:0] writereg_w,
  input  logic            memtoreg_e,
  input  logic            regwrite_m,
  input  logic            regwrite_w,
  input  logic            branch_m,
  input  logic            zero_m,
  input  logic            jump_d,
  output logic            stall_f,
  output logic            stall_d,
  output logic            flush_d,
  output logic            pcsrc_m,
  output logic            jump_d_o,
  output logic            bubble_e,
  output logic [1:0]      forward_a_e,
  output logic [1:0]      forward_b_e
);

  logic lwstall;

  // M-stage result beats W-stage result; register 0 is hardwired zero.
  function automatic fwd_t fwd_sel(input logic [REGW-1:0] src,
                                   input logic [REGW-1:0] wm,
                                   input logic [REGW-1:0] ww,
                                   input logic            rwm,
                                   input logic            rww);
    fwd_t sel;
    sel = FWD_RF;
    if ((src != '0) && (src == wm) && rwm)      sel = FWD_M;
    else if ((src != '0) && (src == ww) && rww) sel = FWD_W;
    return sel;
  endfunction

  // Stall/flush decisions; a taken branch squashes the stalled instruction,
  // so it overrides both the load-use stall and a jump in D.
  always_comb begin
    lwstall  = memtoreg_e && (rt_e != '0) && ((rt_e == rs_d) || (rt_e == rt_d));
    pcsrc_m  = branch_m & zero_m;
    stall_f  = lwstall & ~pcsrc_m;
    stall_d  = lwstall & ~pcsrc_m;
    jump_d_o = jump_d & ~lwstall & ~pcsrc_m;
    flush_d  = pcsrc_m | jump_d_o;
    bubble_e = lwstall | pcsrc_m;
  end

  // Operand A follows rs, operand B follows rt.
  always_comb begin
    forward_a_e = fwd_sel(rs_e, writereg_m, writereg_w, regwrite_m, regwrite_w);
    forward_b_e = fwd_sel(rt_e, writereg_m, writereg_w, regwrite_m, regwrite_w);
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline: carries decoded control through E, M and W and
// applies stall/bubble decisions from the hazard unit.
module ctrl_pipe
  import mips_ctrl_pkg::*;
#(
  parameter int REGW  = 5,
  parameter int ALUCW = CTRL_ALUCW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             regwrite_d,
  input  logic             memtoreg_d,
  input  logic             memwrite_d,
  input  logic             alusrc_d,
  input  logic             regdst_d,
  input  logic             branch_d,
  input  logic             jump_d,
  input  logic [ALUCW-1:0] alucontrol_d,
  input  logic [REGW-1:0]  rs_d,
  input  logic [REGW-1:0]  rt_d,
  input  logic [REGW-1:0]  rd_d,
  input  logic             zero_m,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             pcsrc_m,
  output logic             jump_d_o,
  output logic             regwrite_e,
  output logic             regwrite_m,
  output logic             regwrite_w,
  output logic             memtoreg_e,
  output logic             memtoreg_m,
  output logic             memtoreg_w,
  output logic             memwrite_e,
  output logic             memwrite_m,
  output logic             alusrc_e,
  output logic             regdst_e,
  output logic [ALUCW-1:0] alucontrol_e,
  output logic [REGW-1:0]  writereg_e,
  output logic [REGW-1:0]  writereg_m,
  output logic [REGW-1:0]  writereg_w,
  output logic [REGW-1:0]  rs_e,
  output logic [REGW-1:0]  rt_e,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e
);

  ctrl_t           ctrl_d;
  ctrl_t           ctrl_e;
  logic [REGW-1:0] rd_e;
  logic            branch_m;
  logic            bubble_e;
  logic            unused_jump_e;

  assign ctrl_d = {regwrite_d, memtoreg_d, memwrite_d, alusrc_d,
                   regdst_d, branch_d, jump_d, alucontrol_d};

  // D->E register: loads a bubble on reset, load-use stall or taken branch.
  always_ff @(posedge clk) begin
    if (reset || bubble_e) begin
      ctrl_e <= CTRL_BUBBLE;
      rs_e   <= '0;
      rt_e   <= '0;
      rd_e   <= '0;
    end else begin
      ctrl_e <= ctrl_d;
      rs_e   <= rs_d;
      rt_e   <= rt_d;
      rd_e   <= rd_d;
    end
  end

  // Jump has already redirected fetch in D; its E copy has no consumer.
  assign unused_jump_e = ctrl_e.jump;

  assign regwrite_e   = ctrl_e.regwrite;
  assign memtoreg_e   = ctrl_e.memtoreg;
  assign memwrite_e   = ctrl_e.memwrite;
  assign alusrc_e     = ctrl_e.alusrc;
  assign regdst_e     = ctrl_e.regdst;
  assign alucontrol_e = ctrl_e.alucontrol;
  assign writereg_e   = ctrl_e.regdst ? rd_e : rt_e;

  // E->M register: never stalls; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_m <= 1'b0;
      memtoreg_m <= 1'b0;
      memwrite_m <= 1'b0;
      branch_m   <= 1'b0;
      writereg_m <= '0;
    end else begin
      regwrite_m <= ctrl_e.regwrite;
      memtoreg_m <= ctrl_e.memtoreg;
      memwrite_m <= ctrl_e.memwrite;
      branch_m   <= ctrl_e.branch;
      writereg_m <= writereg_e;
    end
  end

  // M->W register: never stalls; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_w <= 1'b0;
      memtoreg_w <= 1'b0;
      writereg_w <= '0;
    end else begin
      regwrite_w <= regwrite_m;
      memtoreg_w <= memtoreg_m;
      writereg_w <= writereg_m;
    end
  end

  hazard_unit #(.REGW(REGW)) u_hazard (
    .rs_d        (rs_d),
    .rt_d        (rt_d),
    .rs_e        (rs_e),
    .rt_e        (rt_e),
    .writereg_m  (writereg_m),
    .writereg_w  (writereg_w),
    .memtoreg_e  (ctrl_e.memtoreg),
    .regwrite_m  (regwrite_m),
    .regwrite_w  (regwrite_w),
    .branch_m    (branch_m),
    .zero_m      (zero_m),
    .jump_d      (jump_d),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .pcsrc_m     (pcsrc_m),
    .jump_d_o    (jump_d_o),
    .bubble_e    (bubble_e),
    .forward_a_e (forward_a_e),
    .forward_b_e (forward_b_e)
  );

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe with a cycle-tagged expectation scoreboard.
module tb_ctrl_pipe;

  localparam int REGW  = 5;
  localparam int ALUCW = 3;

  // observable selectors
  localparam int S_STALLF = 0,  S_STALLD = 1,  S_FLUSH = 2,  S_PCSRC = 3;
  localparam int S_JUMP   = 4,  S_RWE    = 5,  S_RWM   = 6,  S_RWW   = 7;
  localparam int S_WRE    = 8,  S_WRM    = 9,  S_RTE   = 10, S_FA    = 11;
  localparam int S_FB     = 12, S_EALL   = 13, S_ALL   = 14;

  logic             clk = 1'b0;
  logic             reset;
  logic             regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d;
  logic             branch_d, jump_d;
  logic [ALUCW-1:0] alucontrol_d;
  logic [REGW-1:0]  rs_d, rt_d, rd_d;
  logic             zero_m;
  logic             stall_f, stall_d, flush_d, pcsrc_m, jump_d_o;
  logic             regwrite_e, regwrite_m, regwrite_w;
  logic             memtoreg_e, memtoreg_m, memtoreg_w;
  logic             memwrite_e, memwrite_m, alusrc_e, regdst_e;
  logic [ALUCW-1:0] alucontrol_e;
  logic [REGW-1:0]  writereg_e, writereg_m, writereg_w, rs_e, rt_e;
  logic [1:0]       forward_a_e, forward_b_e;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc        = 0;
  int   vectors    = 0;
  int   miscompares = 0;

  ctrl_pipe #(.REGW(REGW), .ALUCW(ALUCW)) dut (
    .clk(clk), .reset(reset),
    .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d), .memwrite_d(memwrite_d),
    .alusrc_d(alusrc_d), .regdst_d(regdst_d), .branch_d(branch_d), .jump_d(jump_d),
    .alucontrol_d(alucontrol_d), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
    .zero_m(zero_m),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .pcsrc_m(pcsrc_m),
    .jump_d_o(jump_d_o),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m), .memtoreg_w(memtoreg_w),
    .memwrite_e(memwrite_e), .memwrite_m(memwrite_m),
    .alusrc_e(alusrc_e), .regdst_e(regdst_e), .alucontrol_e(alucontrol_e),
    .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
    .rs_e(rs_e), .rt_e(rt_e),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: run time limit reached, actual cycle %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] obs(input int sel);
    logic [31:0] v;
    v = '0;
    case (sel)
      S_STALLF: v = 32'(stall_f);
      S_STALLD: v = 32'(stall_d);
      S_FLUSH:  v = 32'(flush_d);
      S_PCSRC:  v = 32'(pcsrc_m);
      S_JUMP:   v = 32'(jump_d_o);
      S_RWE:    v = 32'(regwrite_e);
      S_RWM:    v = 32'(regwrite_m);
      S_RWW:    v = 32'(regwrite_w);
      S_WRE:    v = 32'(writereg_e);
      S_WRM:    v = 32'(writereg_m);
      S_RTE:    v = 32'(rt_e);
      S_FA:     v = 32'(forward_a_e);
      S_FB:     v = 32'(forward_b_e);
      S_EALL:   v = 32'({regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e,
                         alucontrol_e, rs_e, rt_e, writereg_e});
      S_ALL:    v = 32'(|{regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m,
                          memtoreg_w, memwrite_e, memwrite_m, alusrc_e, regdst_e,
                          alucontrol_e, writereg_e, writereg_m, writereg_w, rs_e, rt_e});
      default:  v = 32'hdead_beef;
    endcase
    return v;
  endfunction

  // scoreboard monitor: compares every expectation tagged for this cycle
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        logic [31:0] act;
        act = obs(exp_q[i].sel);
        vectors = vectors + 1;
        if (act !== exp_q[i].val) begin
          miscompares = miscompares + 1;
          $display("FAIL %s @cyc %0d: actual %0h, required %0h",
                   exp_q[i].name, cyc, act, exp_q[i].val);
        end
        exp_q.delete(i);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int off, input int sel, input logic [31:0] v,
                           input string nm);
    exp_t e;
    e.cyc  = cyc + off;
    e.sel  = sel;
    e.val  = v;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic set_d(input logic rw, input logic mtr, input logic mw,
                       input logic asrc, input logic rdst, input logic br,
                       input logic jmp, input logic [2:0] aluc,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd);
    regwrite_d = rw;  memtoreg_d = mtr; memwrite_d = mw; alusrc_d = asrc;
    regdst_d = rdst;  branch_d = br;    jump_d = jmp;    alucontrol_d = aluc;
    rs_d = rs; rt_d = rt; rd_d = rd;
  endtask

  // next cycle's D-stage instruction
  task automatic iss(input logic rw, input logic mtr, input logic mw,
                     input logic asrc, input logic rdst, input logic br,
                     input logic jmp, input logic [2:0] aluc,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd);
    tick();
    set_d(rw, mtr, mw, asrc, rdst, br, jmp, aluc, rs, rt, rd);
  endtask

  task automatic pad(input int n);
    repeat (n) iss(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
  endtask

  // R-type add writing rd, beq, lw rt
  task automatic add_i(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    iss(1, 0, 0, 0, 1, 0, 0, 3'b010, rs, rt, rd);
  endtask
  task automatic beq_i();
    iss(0, 0, 0, 0, 0, 1, 0, 3'b110, 5'd1, 5'd2, 5'd0);
  endtask
  task automatic lw_i(input logic [4:0] rt);
    iss(1, 1, 0, 1, 0, 0, 0, 3'b010, 5'd1, rt, 5'd0);
  endtask

  initial begin
    reset  = 1'b1;
    zero_m = 1'b0;
    set_d(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);

    // reset held for two edges with regwrite_d=1
    tick();
    expect_at(0, S_ALL, 0, "rst_cyc1_zero");
    expect_at(0, S_STALLF, 0, "rst_stall_f");
    tick();
    expect_at(0, S_ALL, 0, "rst_cyc2_zero");
    reset = 1'b0;
    expect_at(1, S_RWE, 1, "rst_rw_e_after");
    expect_at(1, S_RWM, 0, "rst_rw_m_after");
    expect_at(3, S_RWW, 1, "rst_rw_w_latency");
    pad(4);

    // forward from M
    add_i(5'd1, 5'd2, 5'd3);
    expect_at(1, S_WRE, 3, "wr_e_regdst");
    add_i(5'd3, 5'd4, 5'd6);
    expect_at(1, S_FA, 2, "fwd_a_from_m");
    expect_at(1, S_FB, 0, "fwd_b_regfile");
    pad(3);

    // forward from W with one independent instruction between
    add_i(5'd1, 5'd2, 5'd3);
    add_i(5'd1, 5'd2, 5'd7);
    add_i(5'd3, 5'd4, 5'd6);
    expect_at(1, S_FA, 1, "fwd_a_from_w");
    pad(3);

    // M wins over W for the same register
    add_i(5'd1, 5'd2, 5'd3);
    add_i(5'd1, 5'd2, 5'd3);
    add_i(5'd3, 5'd4, 5'd6);
    expect_at(1, S_FA, 2, "fwd_a_m_priority");
    pad(3);

    // register 0 never forwarded
    add_i(5'd1, 5'd2, 5'd0);
    add_i(5'd0, 5'd0, 5'd4);
    expect_at(1, S_FA, 0, "fwd_a_reg0");
    expect_at(1, S_FB, 0, "fwd_b_reg0");
    pad(3);

    // load-use: one stall cycle, one bubble, then forward from W
    lw_i(5'd5);
    add_i(5'd2, 5'd5, 5'd8);
    expect_at(0, S_STALLF, 1, "lw_stall_f");
    expect_at(0, S_STALLD, 1, "lw_stall_d");
    expect_at(0, S_FLUSH, 0, "lw_no_flush");
    expect_at(1, S_STALLF, 0, "lw_stall_one_cycle");
    expect_at(1, S_EALL, 0, "lw_e_bubble");
    expect_at(2, S_FB, 1, "lw_fwd_b_from_w");
    expect_at(2, S_RTE, 5, "lw_dep_in_e");
    add_i(5'd2, 5'd5, 5'd8);  // held in IF-ID by the stall
    pad(3);

    // taken branch
    beq_i();
    add_i(5'd1, 5'd2, 5'd10);
    add_i(5'd1, 5'd2, 5'd9);
    zero_m = 1'b1;
    expect_at(0, S_PCSRC, 1, "br_pcsrc");
    expect_at(0, S_FLUSH, 1, "br_flush");
    expect_at(1, S_EALL, 0, "br_e_bubble");
    expect_at(1, S_RWM, 1, "br_m_completes");
    expect_at(1, S_WRM, 10, "br_m_wr");
    pad(1);
    zero_m = 1'b0;
    pad(3);

    // branch not taken
    beq_i();
    add_i(5'd1, 5'd2, 5'd10);
    add_i(5'd1, 5'd2, 5'd9);
    expect_at(0, S_PCSRC, 0, "nbr_pcsrc");
    expect_at(0, S_FLUSH, 0, "nbr_flush");
    expect_at(1, S_RWE, 1, "nbr_e_kept");
    expect_at(1, S_WRE, 9, "nbr_e_wr");
    pad(3);

    // load-use coinciding with taken branch
    beq_i();
    lw_i(5'd5);
    add_i(5'd2, 5'd5, 5'd8);
    zero_m = 1'b1;
    expect_at(0, S_STALLF, 0, "brlw_stall_f");
    expect_at(0, S_STALLD, 0, "brlw_stall_d");
    expect_at(0, S_FLUSH, 1, "brlw_flush");
    expect_at(0, S_PCSRC, 1, "brlw_pcsrc");
    expect_at(1, S_EALL, 0, "brlw_e_bubble");
    pad(1);
    zero_m = 1'b0;
    pad(3);

    // plain jump
    iss(0, 0, 0, 0, 0, 0, 1, 3'b000, 0, 0, 0);
    expect_at(0, S_JUMP, 1, "jmp_taken");
    expect_at(0, S_FLUSH, 1, "jmp_flush");
    pad(3);

    // jump coinciding with taken branch
    beq_i();
    pad(1);
    iss(0, 0, 0, 0, 0, 0, 1, 3'b000, 0, 0, 0);
    zero_m = 1'b1;
    expect_at(0, S_JUMP, 0, "brjmp_jump_off");
    expect_at(0, S_PCSRC, 1, "brjmp_pcsrc");
    expect_at(0, S_FLUSH, 1, "brjmp_flush");
    pad(1);
    zero_m = 1'b0;
    pad(3);

    // reset during an active load-use stall
    lw_i(5'd5);
    add_i(5'd2, 5'd5, 5'd8);
    expect_at(0, S_STALLF, 1, "rstlw_pre_stall");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_at(0, S_STALLF, 0, "rstlw_no_stall");
    expect_at(0, S_ALL, 0, "rstlw_all_zero");
    pad(5);

    if (exp_q.size() != 0) begin
      miscompares = miscompares + exp_q.size();
      $display("FAIL scoreboard_drain: actual %0d pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
